test_framegen: RTL

//  Parametrised test-frame generator for PC readout bring-up. Emits a periodic frame trigger and,

---
 rtl/test_framegen_if.sv | 27 ++
 rtl/test_framegen.sv | 130 +++++++++++++
 2 files changed

// File: rtl/test_framegen_if.sv
// rtl/test_framegen_if.sv - readout buffer write port and PC toggle handshake
interface test_framegen_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) ();
  logic              handshakePC;
  logic              handshakeFPGA;
  logic              we;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;

  modport master (
    input  handshakePC,
    output handshakeFPGA,
    output we,
    output address,
    output data
  );

  modport slave (
    output handshakePC,
    input  handshakeFPGA,
    input  we,
    input  address,
    input  data
  );
endinterface

// File: rtl/test_framegen.sv
// rtl/test_framegen.sv - periodic test-frame generator driving the readout buffer
module test_framegen #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int PERIOD = 524288
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [1:0]        mode,
  test_framegen_if.master   bus,
  output logic [DATA_W-1:0] framecount,
  output logic [DATA_W-1:0] dropcount
);

  localparam int                CTR_W     = $clog2(PERIOD);
  localparam logic [CTR_W-1:0]  CTR_LAST  = CTR_W'(PERIOD - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  // A frame plus its DONE cycle must fit between two ticks.
  if (PERIOD < (2 ** ADDR_W) + 3) begin : g_period_check
    $error("test_framegen: PERIOD must be >= 2**ADDR_W + 3");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DUMPING = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CTR_W-1:0]  ctr;
  logic              tick;
  logic              start;
  logic              drop;
  logic              we;
  logic [ADDR_W-1:0] address;
  logic              hs_fpga;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] frame_q;
  logic [DATA_W-1:0] data;

  assign tick = (ctr == CTR_LAST);
  assign we   = (state == DUMPING);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state, frame start and drop decisions.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    drop       = 1'b0;
    case (state)
      IDLE: begin
        if (tick && enable) begin
          if (bus.handshakePC == hs_fpga) begin
            start      = 1'b1;
            state_next = DUMPING;
          end else begin
            drop = 1'b1;
          end
        end
      end
      DUMPING: begin
        drop = tick;
        if (address == ADDR_LAST) state_next = DONE;
      end
      DONE: begin
        drop       = tick;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Tick divider, tick count and saturating drop count.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctr        <= '0;
      framecount <= '0;
      dropcount  <= '0;
    end else begin
      ctr <= tick ? '0 : ctr + CTR_W'(1);
      if (tick) framecount <= framecount + DATA_W'(1);
      if (drop && (dropcount != '1)) dropcount <= dropcount + DATA_W'(1);
    end
  end

  // Frame parameters latched at start, write address walk and handshake toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= '0;
      frame_q <= '0;
      address <= '0;
      hs_fpga <= 1'b0;
    end else begin
      if (start) begin
        mode_q  <= mode;
        frame_q <= framecount + DATA_W'(1);
      end
      if (we && (address != ADDR_LAST)) address <= address + ADDR_W'(1);
      else                              address <= '0;
      if (we && (address == ADDR_LAST)) hs_fpga <= ~hs_fpga;
    end
  end

  // Write data pattern; held at zero outside a frame.
  always_comb begin
    data = '0;
    if (we) begin
      case (mode_q)
        2'd0:    data = frame_q;
        2'd1:    data = {frame_q[DATA_W-ADDR_W-1:0], address};
        2'd2:    data = {{(DATA_W-ADDR_W){1'b0}}, address};
        default: data = {(DATA_W/2){2'b10}} ^ {DATA_W{address[0]}};
      endcase
    end
  end

  assign bus.we            = we;
  assign bus.address       = address;
  assign bus.data          = data;
  assign bus.handshakeFPGA = hs_fpga;

endmodule
